servile_rr_arbiter: RTL
=======================

# servile_rr_arbiter

Parametrised N-master Wishbone arbiter feeding one shared memory port. It generalises the fixed two-master instruction/data arbiter to NM masters with registered round-robin grant. Masters may request simultaneously; each accepted master holds the grant until its transaction completes or it aborts. The block sits between the CPU bus masters (ibus, dbus, debug/DMA) and the single memory slave in the servile wrapper.

## Interface
Parameters:
- NM, 2: number of masters, 2..8.
- AW, 32: address width.
- DW, 32: data width; SW = DW/8 select bits.
- TIMEOUT, 255: cycles in BUSY before forced completion. Used only with SERVILE_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wb_m_adr  in  NM*AW  master addresses, master k at [k*AW +: AW].
- i_wb_m_dat  in  NM*DW  master write data.
- i_wb_m_sel  in  NM*SW  master byte selects.
- i_wb_m_we  in  NM  master write enables.
- i_wb_m_stb  in  NM  master strobes (request).
- o_wb_m_rdt  out  DW  read data, broadcast to all masters.
- o_wb_m_ack  out  NM  per-master ack, one-hot or zero.
- o_wb_m_err  out  NM  per-master timeout error; constant 0 without the macro.
- o_wb_mem_adr  out  AW  / o_wb_mem_dat out DW / o_wb_mem_sel out SW / o_wb_mem_we out 1 / o_wb_mem_stb out 1: slave request.
- i_wb_mem_rdt  in  DW  slave read data.
- i_wb_mem_ack  in  1  slave ack.
- o_grant  out  NM  current one-hot grant, for debug and performance counters.

## Operation
- FSM states: IDLE and BUSY. Reset puts the FSM in IDLE and sets the grant to 0 and the priority pointer `ptr` to 0.
- IDLE: if any i_wb_m_stb is set, pick the first requesting master scanning ptr, ptr+1, …, NM-1, 0, …, ptr-1. Register grant = onehot(winner). Go to BUSY.
- BUSY, output mux:
  - o_wb_mem_stb = i_wb_m_stb[g].
  - adr, dat, sel and we come from master g.
  - we is gated by stb.
- BUSY, ack routing: o_wb_m_ack[g] = i_wb_mem_ack. All other acks are 0.
- BUSY, completion: on i_wb_mem_ack, go to IDLE, clear the grant, and set ptr = (g+1) mod NM.
- Abort: if i_wb_m_stb[g] drops in BUSY without an ack, go to IDLE and clear the grant. ptr is still set to g+1. A late i_wb_mem_ack in IDLE is ignored and produces no master ack.
- In IDLE, o_wb_mem_stb, adr, dat, sel and we are all 0.
- o_wb_m_rdt = i_wb_mem_rdt, combinational and ungated.
- Requests from non-granted masters are held pending and never dropped.
- ptr width is $clog2(NM). Wrap is modulo NM; for non-power-of-two NM, NM-1 wraps to 0.

## Timing
- Reset values: all outputs 0; the FSM is in IDLE.
- Arbitration latency: stb seen in IDLE at cycle n → o_wb_mem_stb at n+1.
- Ack path: combinational, same cycle as i_wb_mem_ack.
- Per-transaction overhead: 1 IDLE cycle. Back-to-back grants are never issued in consecutive cycles.
- Masters follow Wishbone classic: stb held until ack, then deasserted on the next cycle. A stb still high in the IDLE cycle after an ack counts as a new request.
- Fairness: for NM masters that all request continuously, each is served once per NM grants.
- Reset asserted in BUSY: o_wb_mem_stb falls immediately (asynchronous). No ack is produced.

## Configuration
- SERVILE_ARB_TIMEOUT_EN, defined:
  - An 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT without an ack, pulse o_wb_m_err[g] and o_wb_m_ack[g] for 1 cycle.
  - The FSM then goes to IDLE and ptr advances.
  - A real ack in the same cycle takes precedence: ack only, no err.
- SERVILE_ARB_TIMEOUT_EN, undefined: no counter is instantiated, o_wb_m_err is tied to 0, and a hung slave stalls forever.

## Structure
- Package servile_arb_pkg holds:
  - the FSM state enum (ARB_IDLE, ARB_BUSY);
  - a localparam function for ptr width;
  - the default TIMEOUT constant.
- Sub-module servile_rr_pick is a combinational round-robin picker. Inputs: req[NM], ptr. Output: one-hot gnt[NM]. It is instantiated once.

## Test plan
- NM=2: master 1 requests alone at adr 0x100, and the slave acks 2 cycles after stb → o_wb_mem_stb one cycle after request, o_wb_m_ack=2'b10 with the ack, o_grant=2'b10 during BUSY.
- NM=3: all three stb high and ptr=0 → grants in order 0,1,2,0. Each has 1 idle cycle between. o_wb_mem_adr matches the granted master's address.
- NM=3: master 0 writes (we=1, sel=4'b0011, dat=0xDEADBEEF) while master 2 requests a read → write forwarded first. Master 2 then gets o_wb_m_rdt=0x12345678 with o_wb_m_ack=3'b100.
- Abort: master 1 drops stb in BUSY with no ack, and the slave then acks late → no master ack. FSM returns to IDLE and ptr=2.
- Reset mid-BUSY → all outputs 0 asynchronously. After release, the first request is served from ptr=0.
- With SERVILE_ARB_TIMEOUT_EN and TIMEOUT=16, the slave never acks → ack and err for master g pulse exactly 16 BUSY cycles after grant. The next requester is then served.

Source files
------------

// File: rtl/servile_arb_pkg.sv
// Shared types and constants for the servile N-master round-robin arbiter.
package servile_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam int ARB_TIMEOUT_DEFAULT = 255;

   function automatic int ptr_w(input int nm);
      return ($clog2(nm) < 1) ? 1 : $clog2(nm);
   endfunction

endpackage

// File: rtl/servile_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
module servile_rr_pick
   import servile_arb_pkg::*;
#(
   parameter int NM = 2,
   parameter int PW = 1
) (
   input  logic [NM-1:0] req,
   input  logic [PW-1:0] ptr,
   output logic [NM-1:0] gnt
);

   logic        found;
   int unsigned slot;

   // Outer loop walks the priority order; inner loop keeps every index a loop constant.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      slot  = 0;
      for (int unsigned i = 0; i < NM; i++) begin
         slot = 32'(ptr) + i;
         if (slot >= NM)
            slot = slot - NM;
         for (int unsigned j = 0; j < NM; j++) begin
            if (!found && (j == slot) && req[j]) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/servile_rr_arbiter.sv
// N-master Wishbone classic arbiter with registered round-robin grant onto one memory port.
// Optional BUSY watchdog enabled by defining SERVILE_ARB_TIMEOUT_EN.
module servile_rr_arbiter
   import servile_arb_pkg::*;
#(
   parameter int NM      = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NM*AW-1:0]     i_wb_m_adr,
   input  logic [NM*DW-1:0]     i_wb_m_dat,
   input  logic [NM*(DW/8)-1:0] i_wb_m_sel,
   input  logic [NM-1:0]        i_wb_m_we,
   input  logic [NM-1:0]        i_wb_m_stb,
   output logic [DW-1:0]        o_wb_m_rdt,
   output logic [NM-1:0]        o_wb_m_ack,
   output logic [NM-1:0]        o_wb_m_err,
   output logic [AW-1:0]        o_wb_mem_adr,
   output logic [DW-1:0]        o_wb_mem_dat,
   output logic [DW/8-1:0]      o_wb_mem_sel,
   output logic                 o_wb_mem_we,
   output logic                 o_wb_mem_stb,
   input  logic [DW-1:0]        i_wb_mem_rdt,
   input  logic                 i_wb_mem_ack,
   output logic [NM-1:0]        o_grant
);

   localparam int SW = DW / 8;
   localparam int PW = ptr_w(NM);

   if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
      $error("servile_rr_arbiter: TIMEOUT must fit a 16-bit counter");
   end

   arb_state_t    state, state_n;
   logic [NM-1:0] grant, grant_n, pick_gnt;
   logic [PW-1:0] ptr, ptr_n, ptr_adv;
   logic          stb_g;
   logic          tmo;

   servile_rr_pick #(.NM(NM), .PW(PW)) u_pick (
      .req (i_wb_m_stb),
      .ptr (ptr),
      .gnt (pick_gnt)
   );

   assign o_grant    = grant;
   assign o_wb_m_rdt = i_wb_mem_rdt;
   assign stb_g      = |(i_wb_m_stb & grant);

   always_comb begin
      ptr_adv = '0;
      for (int unsigned k = 0; k < NM; k++) begin
         if (grant[k])
            ptr_adv = (k == NM - 1) ? '0 : PW'(k + 1);
      end
   end

`ifdef SERVILE_ARB_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         tmo_cnt <= '0;
      else if (state == ARB_IDLE)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 16'd1;
   end

   assign tmo        = (state == ARB_BUSY) && (tmo_cnt == 16'(TIMEOUT));
   assign o_wb_m_err = grant & {NM{tmo & ~i_wb_mem_ack}};
`else
   assign tmo        = 1'b0;
   assign o_wb_m_err = '0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ARB_IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         ptr   <= ptr_n;
      end
   end

   // Completion, abort and timeout all release the grant and advance ptr past g.
   always_comb begin
      state_n = state;
      grant_n = grant;
      ptr_n   = ptr;
      case (state)
         ARB_IDLE: begin
            if (|i_wb_m_stb) begin
               state_n = ARB_BUSY;
               grant_n = pick_gnt;
            end
         end
         ARB_BUSY: begin
            if (i_wb_mem_ack || tmo || !stb_g) begin
               state_n = ARB_IDLE;
               grant_n = '0;
               ptr_n   = ptr_adv;
            end
         end
         default: begin
            state_n = ARB_IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_comb begin
      o_wb_mem_adr = '0;
      o_wb_mem_dat = '0;
      o_wb_mem_sel = '0;
      o_wb_mem_we  = 1'b0;
      o_wb_mem_stb = 1'b0;
      o_wb_m_ack   = '0;
      if (state == ARB_BUSY) begin
         for (int unsigned k = 0; k < NM; k++) begin
            if (grant[k]) begin
               o_wb_mem_adr = i_wb_m_adr[k*AW +: AW];
               o_wb_mem_dat = i_wb_m_dat[k*DW +: DW];
               o_wb_mem_sel = i_wb_m_sel[k*SW +: SW];
               o_wb_mem_we  = i_wb_m_we[k] & i_wb_m_stb[k];
            end
         end
         o_wb_mem_stb = stb_g;
         o_wb_m_ack   = grant & {NM{i_wb_mem_ack | tmo}};
      end
   end

endmodule
